serv_spi_mem_ctrl: RTL and testbench
====================================

// Module: serv_spi_mem_ctrl
// PURPOSE
//   Wishbone-to-SPI memory controller for the SERV SoC. Each Wishbone access from
//   the CPU becomes one serial SPI transaction to an external SPI flash or SRAM.
//   It sits between the servant memory bus and the chip pins, so program and data
//   storage leave the die. Blocking: one transaction in flight, no caching.
// PARAMETERS
//   CLK_DIV   2  wb_clk cycles per SCLK half-period (legal range 1..255)
//   WRITE_EN  1  1: writes issue SPI WRITE (0x02). 0: writes acked, no SPI activity
//   ADR_W     24 SPI byte-address width sent on the wire (fixed at 24)
// PORTS
//   wb_clk     in   1   system clock; all logic on the rising edge
//   wb_rst     in   1   synchronous reset, active high
//   i_wb_adr   in   32  byte address; only [23:2] used, [1:0] ignored
//   i_wb_dat   in   32  write data
//   i_wb_sel   in   4   byte enables
//   i_wb_we    in   1   1 = write, 0 = read
//   i_wb_cyc   in   1   request; held high until o_wb_ack
//   o_wb_rdt   out  32  read data; valid only in the o_wb_ack cycle
//   o_wb_ack   out  1   single-cycle completion strobe
//   spi_sclk   out  1   SPI clock, mode 0 (idle low)
//   spi_cs_n   out  1   chip select, active low
//   spi_mosi   out  1   serial data to memory
//   spi_miso   in   1   serial data from memory
// BEHAVIOUR
//   Reset (wb_rst=1 at an edge): next cycle spi_cs_n=1, spi_sclk=0, spi_mosi=0,
//     o_wb_ack=0, o_wb_rdt=0, FSM=IDLE. Reset mid-transfer aborts it: no ack, CS high.
//   FSM: IDLE -> CMD(8b) -> ADDR(24b) -> DATA(8*nbytes) -> ACK -> GAP -> IDLE.
//   IDLE: if i_wb_cyc=1, latch adr/dat/sel/we and drive spi_cs_n=0 next cycle.
//     Write with WRITE_EN=0 or sel=0: go straight to ACK, CS stays high.
//   Opcode: read 0x03, write 0x02. All fields are sent MSB-first.
//   Read: start address {adr[23:2],2'b00}. Read 4 bytes. Byte k lands in rdt[8k+7:8k]
//     (little-endian).
//   Write: lo/hi = lowest/highest set bit of sel. Start address is adr+lo.
//     Send bytes lo..hi inclusive. A zero byte between lo and hi is still sent
//     from i_wb_dat.
//   Bit timing:
//     - MOSI changes only while SCLK is low. The first bit is valid when CS falls.
//     - MISO is sampled on the SCLK rising edge.
//     - SCLK high and low each last CLK_DIV cycles.
//   Bit count: NBITS = 32 + 8*nbytes. nbytes = 4 for reads, hi-lo+1 for writes.
//   Latency: o_wb_ack is high exactly 2 + 2*CLK_DIV*NBITS cycles after the cycle
//     in which IDLE samples i_wb_cyc=1. For the no-SPI write path, ack comes 1 cycle
//     after that cycle.
//   ACK state:
//     - spi_cs_n=1 and spi_sclk=0 for the whole state.
//     - o_wb_ack=1 for exactly 1 cycle; o_wb_rdt holds assembled data, else 0.
//   GAP: one cycle with CS high and i_wb_cyc ignored. The master drops cyc here,
//     so a request is never issued twice. The next request is seen no earlier than
//     2 cycles after ack.
//   i_wb_cyc dropped mid-transfer: the SPI transaction completes, the ack is
//     suppressed, and the FSM goes to GAP.
//   o_wb_rdt is 0 in every cycle except the ack of a read.
//   Counters: the bit counter wraps only through FSM reload. The divider restarts
//     at 0 on entry to CMD.
// TESTING
//   1 Reset: wb_rst=1 for 3 cycles mid-read -> cs_n=1, sclk=0, ack=0 the cycle
//     after reset; no later ack.
//   2 Read, CLK_DIV=2: adr=0x0012_3456, model returns 0x11,22,33,44 ->
//     MOSI=0x03,0x123454; rdt=0x44332211; ack at cycle 258.
//   3 Write, sel=4'b0110, dat=0xAABBCCDD, adr=0x100 ->
//     MOSI=0x02,0x000101,0xCC,0xBB; 48 SCLK rising edges; single ack.
//   4 WRITE_EN=0 write, sel=F -> ack 1 cycle after request, cs_n never low.
//     Also sel=0 with WRITE_EN=1 -> same result.
//   5 Back-to-back reads with cyc held one extra cycle after ack ->
//     exactly 2 SPI transactions; cs_n high for >=1 cycle between them.
//   6 CLK_DIV=1 read, cyc dropped at bit 20 -> 64 SCLK pulses still occur,
//     no ack, FSM back in IDLE.

Source files
------------

// File: rtl/serv_spi_mem_ctrl.sv
// Wishbone-to-SPI memory bridge: each Wishbone access becomes one SPI
// READ (0x03) or WRITE (0x02) transaction, one access in flight at a time.
module serv_spi_mem_ctrl #(
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          WRITE_EN = 1'b1,
    parameter int unsigned ADR_W    = 24
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BITS_W = 6;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BITS_W-1:0] ADDR_LAST = BITS_W'(ADR_W - 1);
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ACK,
        S_GAP
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BITS_W-1:0]  bit_left;
    logic [BITS_W-1:0]  data_bits;
    logic [63:0]        tx_sh;
    logic [31:0]        rx_sh;
    logic               is_read;
    logic               aborted;
    logic               tail;

    logic [1:0]         sel_lo;
    logic [1:0]         sel_hi;
    logic [2:0]         req_nbytes;
    logic [BITS_W-1:0]  req_dbits;
    logic [31:0]        dat_shift;
    logic [31:0]        wr_field;
    logic [23:0]        base_addr;
    logic [23:0]        req_addr;
    logic [63:0]        req_frame;
    logic               no_spi;
    logic [31:0]        rd_word;
    logic               unused_adr;

    // Lowest and highest enabled byte lane of the request
    always_comb begin
        sel_lo = 2'd0;
        sel_hi = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (i_wb_sel[i]) sel_lo = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (i_wb_sel[i]) sel_hi = 2'(i);
        end
    end

    // Request decode: full serial frame {opcode, address, data} left-aligned
    assign req_nbytes = i_wb_we ? 3'(sel_hi - sel_lo) + 3'd1 : 3'd4;
    assign req_dbits  = {req_nbytes, 3'b000} - 6'd1;
    assign dat_shift  = i_wb_dat >> {sel_lo, 3'b000};
    assign wr_field   = {dat_shift[7:0], dat_shift[15:8], dat_shift[23:16], dat_shift[31:24]};
    assign base_addr  = {i_wb_adr[23:2], 2'b00};
    assign req_addr   = i_wb_we ? base_addr + 24'(sel_lo) : base_addr;
    assign req_frame  = i_wb_we ? {OP_WRITE, req_addr, wr_field} : {OP_READ, req_addr, 32'h0};
    assign no_spi     = i_wb_we && (!WRITE_EN || (i_wb_sel == 4'h0));

    // Bytes arrive first-byte-first; first byte belongs in the low lane
    assign rd_word    = {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
    assign unused_adr = ^{i_wb_adr[31:24], i_wb_adr[1:0]};

    // Transaction FSM with bit engine and registered bus/pin outputs
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_left  <= '0;
            data_bits <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            is_read   <= 1'b0;
            aborted   <= 1'b0;
            tail      <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_rdt  <= '0;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_wb_ack <= 1'b0;
                    o_wb_rdt <= '0;
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b0;
                    spi_mosi <= 1'b0;
                    if (i_wb_cyc) begin
                        if (no_spi) begin
                            state    <= S_ACK;
                            o_wb_ack <= 1'b1;
                        end else begin
                            state     <= S_CMD;
                            spi_cs_n  <= 1'b0;
                            spi_mosi  <= req_frame[63];
                            tx_sh     <= req_frame;
                            div_cnt   <= '0;
                            bit_left  <= BITS_W'(7);
                            data_bits <= req_dbits;
                            is_read   <= !i_wb_we;
                            aborted   <= 1'b0;
                            tail      <= 1'b0;
                        end
                    end
                end

                S_CMD, S_ADDR, S_DATA: begin
                    if (!i_wb_cyc) aborted <= 1'b1;
                    if (tail) begin
                        // One CS-hold cycle after the last SCLK fall, then release
                        tail     <= 1'b0;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        if (aborted || !i_wb_cyc) begin
                            state <= S_GAP;
                        end else begin
                            state    <= S_ACK;
                            o_wb_ack <= 1'b1;
                            o_wb_rdt <= is_read ? rd_word : '0;
                        end
                    end else if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx_sh    <= {rx_sh[30:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            tx_sh    <= tx_sh << 1;
                            spi_mosi <= tx_sh[62];
                            if (bit_left != '0) begin
                                bit_left <= bit_left - BITS_W'(1);
                            end else begin
                                case (state)
                                    S_CMD: begin
                                        state    <= S_ADDR;
                                        bit_left <= ADDR_LAST;
                                    end
                                    S_ADDR: begin
                                        state    <= S_DATA;
                                        bit_left <= data_bits;
                                    end
                                    default: begin
                                        tail     <= 1'b1;
                                        spi_mosi <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                end

                S_ACK: begin
                    o_wb_ack <= 1'b0;
                    o_wb_rdt <= '0;
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b0;
                    state    <= S_GAP;
                end

                S_GAP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serv_spi_mem_ctrl.sv
// Bench for serv_spi_mem_ctrl: SPI memory model on the main instance, plus
// instances with writes disabled and with the fastest divider.
module tb_serv_spi_mem_ctrl;

    typedef struct {
        logic [31:0] rdt;
        logic [63:0] mosi;
        int          nbits;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cyc_v;

    logic [31:0] rdt0, rdt1, rdt2;
    logic        ack0, ack1, ack2;
    logic        sclk0, sclk1, sclk2;
    logic        cs_n0, cs_n1, cs_n2;
    logic        mosi0, mosi1, mosi2;
    logic        miso0, miso1, miso2;
    logic [2:0]  ack_v;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    logic [7:0]  mem [int];
    logic [63:0] cap;
    int          cap_n;
    logic [23:0] rd_addr;
    int          cs_fall0, hi_run, last_gap, cs_low1, sclk2_cnt, ack_cnt0, ack_cnt2;
    logic        prev_cs0, prev_sclk0, prev_sclk2;

    assign ack_v = {ack2, ack1, ack0};

    serv_spi_mem_ctrl #(.CLK_DIV(2), .WRITE_EN(1'b1), .ADR_W(24)) dut0 (
        .wb_clk(clk), .wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc_v[0]), .o_wb_rdt(rdt0), .o_wb_ack(ack0),
        .spi_sclk(sclk0), .spi_cs_n(cs_n0), .spi_mosi(mosi0), .spi_miso(miso0));

    serv_spi_mem_ctrl #(.CLK_DIV(2), .WRITE_EN(1'b0), .ADR_W(24)) dut1 (
        .wb_clk(clk), .wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc_v[1]), .o_wb_rdt(rdt1), .o_wb_ack(ack1),
        .spi_sclk(sclk1), .spi_cs_n(cs_n1), .spi_mosi(mosi1), .spi_miso(miso1));

    serv_spi_mem_ctrl #(.CLK_DIV(1), .WRITE_EN(1'b1), .ADR_W(24)) dut2 (
        .wb_clk(clk), .wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc_v[2]), .o_wb_rdt(rdt2), .o_wb_ack(ack2),
        .spi_sclk(sclk2), .spi_cs_n(cs_n2), .spi_mosi(mosi2), .spi_miso(miso2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic mem_bit(input logic [23:0] a, input int off);
        logic [7:0] b;
        int key;
        key = int'(a) + off / 8;
        b = mem.exists(key) ? mem[key] : 8'h00;
        return b[7 - (off % 8)];
    endfunction

    function automatic logic [31:0] get_rdt(input int d);
        case (d)
            0:       return rdt0;
            1:       return rdt1;
            default: return rdt2;
        endcase
    endfunction

    // SPI memory model and pin monitors, all sampled mid-cycle
    always @(negedge clk) begin
        prev_cs0   <= cs_n0;
        prev_sclk0 <= sclk0;
        prev_sclk2 <= sclk2;
        if (prev_cs0 && !cs_n0) begin
            cap      <= '0;
            cap_n    <= 0;
            miso0    <= 1'b0;
            cs_fall0 <= cs_fall0 + 1;
            last_gap <= hi_run;
        end else if (!prev_sclk0 && sclk0) begin
            cap   <= {cap[62:0], mosi0};
            cap_n <= cap_n + 1;
            if (cap_n == 31) rd_addr <= {cap[22:0], mosi0};
        end else if (prev_sclk0 && !sclk0 && cap_n >= 32 && cap_n < 64) begin
            miso0 <= mem_bit(rd_addr, cap_n - 32);
        end
        hi_run <= cs_n0 ? hi_run + 1 : 0;
        if (!cs_n1) cs_low1 <= cs_low1 + 1;
        if (!prev_sclk2 && sclk2) sclk2_cnt <= sclk2_cnt + 1;
        if (ack0) ack_cnt0 <= ack_cnt0 + 1;
        if (ack2) ack_cnt2 <= ack_cnt2 + 1;
    end

    // Issue one request on instance d; latency counts edges from the sampling edge
    task automatic run_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input logic w, input bit hold,
                           output int lat, output logic [31:0] r,
                           output logic ack_after, output logic [31:0] r_after);
        logic got;
        @(negedge clk);
        adr = a; dat = wd; sel = s; we = w;
        cyc_v[d] = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 600) begin
            @(posedge clk); #1;
            lat++;
            got = ack_v[d];
        end
        r = get_rdt(d);
        if (!got) lat = -1;
        if (!hold) cyc_v[d] = 1'b0;
        @(posedge clk); #1;
        ack_after = ack_v[d];
        r_after = get_rdt(d);
        if (hold) begin
            @(posedge clk); #1;
        end
        cyc_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        int a0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cs_n0 !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n0); end
        n_cmp++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk0); end
        n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack0); end
        n_cmp++; if (rdt0 !== 32'h0) begin n_err++; $display("FAIL reset_rdt: got %h want 0", rdt0); end
        n_cmp++; if (mosi0 !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi0); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        adr = 32'h0012_3456; we = 1'b0; sel = 4'hF; cyc_v[0] = 1'b1;
        repeat (50) @(negedge clk);
        a0 = ack_cnt0;
        rst = 1'b1;
        cyc_v[0] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cs_n0 !== 1'b1) begin n_err++; $display("FAIL abort_reset_cs_n: got %b want 1", cs_n0); end
        n_cmp++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL abort_reset_sclk: got %b want 0", sclk0); end
        n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL abort_reset_ack: got %b want 0", ack0); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        n_cmp++; if (ack_cnt0 !== a0) begin n_err++; $display("FAIL abort_reset_late_ack: got %0d acks want %0d", ack_cnt0, a0); end
        n_cmp++; if (cs_n0 !== 1'b1) begin n_err++; $display("FAIL abort_reset_idle_cs: got %b want 1", cs_n0); end
    endtask

    task automatic test_read();
        int lat;
        logic [31:0] r, r_after;
        logic ack_after;
        exp_t e;
        repeat (3) @(negedge clk);
        sb.push_back('{rdt: 32'h4433_2211, mosi: {32'h0312_3454, 32'h0}, nbits: 64, lat: 2 + 2 * 2 * 64});
        run_req(0, 32'h0012_3456, 32'h0, 4'hF, 1'b0, 1'b0, lat, r, ack_after, r_after);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL read_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (r !== e.rdt) begin n_err++; $display("FAIL read_data: got %h want %h", r, e.rdt); end
        n_cmp++; if (cap !== e.mosi) begin n_err++; $display("FAIL read_mosi: got %h want %h", cap, e.mosi); end
        n_cmp++; if (cap_n !== e.nbits) begin n_err++; $display("FAIL read_sclk_edges: got %0d want %0d", cap_n, e.nbits); end
        n_cmp++; if (ack_after !== 1'b0) begin n_err++; $display("FAIL read_ack_width: got %b want 0", ack_after); end
        n_cmp++; if (r_after !== 32'h0) begin n_err++; $display("FAIL read_rdt_after_ack: got %h want 0", r_after); end
    endtask

    task automatic test_write();
        int lat, a0;
        logic [31:0] r, r_after;
        logic ack_after;
        exp_t e;
        repeat (3) @(negedge clk);
        a0 = ack_cnt0;
        sb.push_back('{rdt: 32'h0, mosi: 64'h0000_0200_0101_CCBB, nbits: 48, lat: 2 + 2 * 2 * 48});
        run_req(0, 32'h0000_0100, 32'hAABB_CCDD, 4'b0110, 1'b1, 1'b0, lat, r, ack_after, r_after);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL write_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (r !== e.rdt) begin n_err++; $display("FAIL write_rdt: got %h want %h", r, e.rdt); end
        n_cmp++; if (cap !== e.mosi) begin n_err++; $display("FAIL write_mosi: got %h want %h", cap, e.mosi); end
        n_cmp++; if (cap_n !== e.nbits) begin n_err++; $display("FAIL write_sclk_edges: got %0d want %0d", cap_n, e.nbits); end
        n_cmp++; if (ack_cnt0 - a0 !== 1) begin n_err++; $display("FAIL write_ack_count: got %0d want 1", ack_cnt0 - a0); end
        n_cmp++; if (ack_after !== 1'b0) begin n_err++; $display("FAIL write_ack_width: got %b want 0", ack_after); end
    endtask

    task automatic test_no_spi_write();
        int lat, c0, f0;
        logic [31:0] r, r_after;
        logic ack_after;
        exp_t e;
        repeat (3) @(negedge clk);
        c0 = cs_low1;
        sb.push_back('{rdt: 32'h0, mosi: 64'h0, nbits: 0, lat: 1});
        run_req(1, 32'h0000_0040, 32'h1234_5678, 4'hF, 1'b1, 1'b0, lat, r, ack_after, r_after);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL nowr_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (cs_low1 !== c0) begin n_err++; $display("FAIL nowr_cs_low_cycles: got %0d want %0d", cs_low1, c0); end
        n_cmp++; if (ack_after !== 1'b0) begin n_err++; $display("FAIL nowr_ack_width: got %b want 0", ack_after); end
        repeat (3) @(negedge clk);
        f0 = cs_fall0;
        sb.push_back('{rdt: 32'h0, mosi: 64'h0, nbits: 0, lat: 1});
        run_req(0, 32'h0000_0080, 32'hCAFE_F00D, 4'h0, 1'b1, 1'b0, lat, r, ack_after, r_after);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL sel0_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (cs_fall0 !== f0) begin n_err++; $display("FAIL sel0_cs_falls: got %0d want %0d", cs_fall0, f0); end
        n_cmp++; if (r !== e.rdt) begin n_err++; $display("FAIL sel0_rdt: got %h want %h", r, e.rdt); end
    endtask

    task automatic test_back_to_back();
        int lat, f0, a0;
        logic [31:0] r, r_after;
        logic ack_after;
        exp_t e;
        repeat (3) @(negedge clk);
        f0 = cs_fall0;
        a0 = ack_cnt0;
        sb.push_back('{rdt: 32'h4433_2211, mosi: {32'h0312_3454, 32'h0}, nbits: 64, lat: 258});
        run_req(0, 32'h0012_3454, 32'h0, 4'hF, 1'b0, 1'b1, lat, r, ack_after, r_after);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (r !== e.rdt) begin n_err++; $display("FAIL b2b_first_data: got %h want %h", r, e.rdt); end
        sb.push_back('{rdt: 32'hDDCC_BBAA, mosi: {32'h0300_0200, 32'h0}, nbits: 64, lat: 258});
        run_req(0, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b0, lat, r, ack_after, r_after);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (r !== e.rdt) begin n_err++; $display("FAIL b2b_second_data: got %h want %h", r, e.rdt); end
        n_cmp++; if (cap !== e.mosi) begin n_err++; $display("FAIL b2b_second_mosi: got %h want %h", cap, e.mosi); end
        repeat (5) @(negedge clk);
        n_cmp++; if (cs_fall0 - f0 !== 2) begin n_err++; $display("FAIL b2b_transactions: got %0d want 2", cs_fall0 - f0); end
        n_cmp++; if (ack_cnt0 - a0 !== 2) begin n_err++; $display("FAIL b2b_acks: got %0d want 2", ack_cnt0 - a0); end
        n_cmp++; if (last_gap < 1) begin n_err++; $display("FAIL b2b_cs_gap: got %0d want >=1", last_gap); end
    endtask

    task automatic test_abort_fast();
        int p0, a2, waited, lat;
        logic [31:0] r, r_after;
        logic ack_after;
        repeat (3) @(negedge clk);
        p0 = sclk2_cnt;
        a2 = ack_cnt2;
        adr = 32'h0012_3454; dat = 32'h0; sel = 4'hF; we = 1'b0;
        cyc_v[2] = 1'b1;
        waited = 0;
        while ((sclk2_cnt - p0) < 20 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        cyc_v[2] = 1'b0;
        n_cmp++; if (waited >= 300) begin n_err++; $display("FAIL abort_wait_bit20: got %0d edges want 20", sclk2_cnt - p0); end
        repeat (150) @(negedge clk);
        n_cmp++; if (sclk2_cnt - p0 !== 64) begin n_err++; $display("FAIL abort_sclk_pulses: got %0d want 64", sclk2_cnt - p0); end
        n_cmp++; if (ack_cnt2 !== a2) begin n_err++; $display("FAIL abort_ack: got %0d acks want %0d", ack_cnt2, a2); end
        n_cmp++; if (cs_n2 !== 1'b1) begin n_err++; $display("FAIL abort_cs_n: got %b want 1", cs_n2); end
        run_req(2, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, lat, r, ack_after, r_after);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL abort_back_to_idle: got latency %0d want 1", lat); end
    endtask

    initial begin
        rst = 1'b1;
        adr = '0; dat = '0; sel = '0; we = 1'b0; cyc_v = '0;
        miso1 = 1'b0; miso2 = 1'b0;
        mem[32'h0012_3454] = 8'h11; mem[32'h0012_3455] = 8'h22;
        mem[32'h0012_3456] = 8'h33; mem[32'h0012_3457] = 8'h44;
        mem[32'h0000_0200] = 8'hAA; mem[32'h0000_0201] = 8'hBB;
        mem[32'h0000_0202] = 8'hCC; mem[32'h0000_0203] = 8'hDD;
        test_reset();
        test_read();
        test_write();
        test_no_spi_write();
        test_back_to_back();
        test_abort_fast();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        cap = '0; cap_n = 0; rd_addr = '0; miso0 = 1'b0;
        cs_fall0 = 0; hi_run = 0; last_gap = 0; cs_low1 = 0; sclk2_cnt = 0;
        ack_cnt0 = 0; ack_cnt2 = 0;
        prev_cs0 = 1'b1; prev_sclk0 = 1'b0; prev_sclk2 = 1'b0;
    end

endmodule
